// File: rtl/audio_arbiter_if.sv
// DAC frame handshake between the audio arbiter and the serial DAC shifter.
// The master side issues frames; the slave side reports when shifting has finished.
interface audio_arbiter_if;
   logic        dac_start;
   logic [11:0] dac_word;
   logic [1:0]  src;
   logic        dac_done;

   modport master (
      output dac_start,
      output dac_word,
      output src,
      input  dac_done
   );

   modport slave (
      input  dac_start,
      input  dac_word,
      input  src,
      output dac_done
   );
endinterface

// File: rtl/audio_arbiter.sv
// Pong audio sequencer: picks song, collision tone or silence for each DAC frame
// and paces frames into the serializer with a one-deep pending sample.
module audio_arbiter #(
   parameter logic [3:0]  WIN_SCORE    = 4'd11,
   parameter logic [15:0] TONE_SAMPLES = 16'd2000,
   parameter logic [11:0] SILENCE_CODE = 12'h000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sample_tick,
   input  logic                   did_collide,
   input  logic [3:0]             p1_score,
   input  logic [3:0]             p2_score,
   input  logic [11:0]            nco_data,
   input  logic [11:0]            adc_data,
   audio_arbiter_if.master        dac,
   output logic [7:0]             dropped
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      BUSY = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic        pending_reg, pending_next;
   logic [7:0]  dropped_reg, dropped_next;
   logic [15:0] tone_cnt_reg, tone_cnt_next;
   logic        dac_start_reg;
   logic [11:0] dac_word_reg, dac_word_next;
   logic [1:0]  src_reg, src_next;

   logic        load_now;
   logic        drop_evt;
   logic        game_over;
   logic        tone_active;

   assign game_over   = (p1_score == WIN_SCORE) || (p2_score == WIN_SCORE);
   assign tone_active = (tone_cnt_reg != 16'd0);

   // State register and all registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         pending_reg   <= 1'b0;
         dropped_reg   <= 8'd0;
         tone_cnt_reg  <= 16'd0;
         dac_start_reg <= 1'b0;
         dac_word_reg  <= SILENCE_CODE;
         src_reg       <= 2'd0;
      end else begin
         state_reg     <= state_next;
         pending_reg   <= pending_next;
         dropped_reg   <= dropped_next;
         tone_cnt_reg  <= tone_cnt_next;
         dac_start_reg <= load_now;
         dac_word_reg  <= dac_word_next;
         src_reg       <= src_next;
      end
   end

   // Next state; load_now marks the edge that enters LOAD and launches a frame
   always_comb begin
      state_next   = state_reg;
      pending_next = pending_reg;
      load_now     = 1'b0;
      drop_evt     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (sample_tick) begin
               state_next = LOAD;
               load_now   = 1'b1;
            end
         end
         LOAD: begin
            state_next = BUSY;
            if (sample_tick) begin
               drop_evt     = pending_reg;
               pending_next = 1'b1;
            end
         end
         BUSY: begin
            if (dac_start_reg == 1'b0 && dac.dac_done) begin
               if (pending_reg || sample_tick) begin
                  // A pending sample is consumed here; a fresh tick only stays
                  // pending if an older one is being consumed this cycle.
                  state_next   = LOAD;
                  load_now     = 1'b1;
                  pending_next = pending_reg && sample_tick;
               end else begin
                  state_next = IDLE;
               end
            end else if (sample_tick) begin
               drop_evt     = pending_reg;
               pending_next = 1'b1;
            end
         end
         default: begin
            state_next   = IDLE;
            pending_next = 1'b0;
         end
      endcase

      dropped_next = dropped_reg;
      if (drop_evt && (dropped_reg != 8'hFF)) begin
         dropped_next = dropped_reg + 8'd1;
      end
   end

   // Source selection and tone length bookkeeping
   always_comb begin
      dac_word_next = dac_word_reg;
      src_next      = src_reg;
      if (load_now) begin
         if (game_over) begin
            dac_word_next = {~adc_data[11], adc_data[10:0]};
            src_next      = 2'd2;
         end else if (tone_active) begin
            dac_word_next = nco_data;
            src_next      = 2'd1;
         end else begin
            dac_word_next = SILENCE_CODE;
            src_next      = 2'd0;
         end
      end

      tone_cnt_next = tone_cnt_reg;
      if (game_over) begin
         tone_cnt_next = 16'd0;
      end else if (did_collide) begin
         tone_cnt_next = TONE_SAMPLES;
      end else if (load_now && tone_active) begin
         tone_cnt_next = tone_cnt_reg - 16'd1;
      end
   end

   assign dac.dac_start = dac_start_reg;
   assign dac.dac_word  = dac_word_reg;
   assign dac.src       = src_reg;
   assign dropped       = dropped_reg;

endmodule
